auto_decision: RTL and testbench
================================

AUTO_DECISION -- requirements
Module: auto_decision

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 5: cycles a detector input must hold a value before its filtered copy updates.
REQ-002 Parameter SETTLE_TIME, default 50: stop cycles before a decision (0.1 s at 500 Hz).
REQ-003 Parameter ACK_TIMEOUT, default 8: cycles allowed for is_turning to rise after a trigger.
REQ-004 Parameter COOLDOWN_TIME, default 250: cycles side openings are ignored after a junction (0.5 s).
REQ-005 Port clk  input  1  single clock (500 Hz); all logic on its rising edge.
REQ-006 Port rst_n  input  1  synchronous, active-low reset.
REQ-007 Port enable  input  1  auto-drive enable; low forces IDLE.
REQ-008 Port detector_front / detector_left / detector_right  input  1 each  1 = wall present, 0 = open.
REQ-009 Port is_turning  input  1  busy flag from the downstream turning stage.
REQ-010 Port trigger_turn_left / trigger_turn_right / trigger_turn_back  output  1 each  one-cycle request pulses to the turning stage.
REQ-011 Port move_forward  output  1  level; 1 = drive straight.
REQ-012 Port turn_count  output  8  number of triggers issued, wraps 255 -> 0.
REQ-013 Port ack_error  output  1  sticky; set on ACK_TIMEOUT expiry.

Function
REQ-014 Each detector SHALL have its own debounce counter; the filtered value SHALL update only after the raw input differs from it for DEBOUNCE_CYCLES consecutive cycles; any reversion clears the counter.
REQ-015 All decisions SHALL use filtered detector values only.
REQ-016 FSM states SHALL be IDLE, FORWARD, SETTLE, DECIDE, ISSUE, WAIT_ACK, WAIT_DONE, COOLDOWN.
REQ-017 IDLE: move_forward=0; enable=1 -> FORWARD next cycle.
REQ-018 FORWARD: move_forward=1; junction event (front=1, or left=0, or right=0) -> SETTLE.
REQ-019 SETTLE: move_forward=0; counter runs SETTLE_TIME cycles; exit to DECIDE only when counter expired AND is_turning=0; otherwise hold.
REQ-020 DECIDE (one cycle), left-hand priority: left=0 -> left; else front=0 -> go straight; else right=0 -> right; else back.
REQ-021 Go-straight decision SHALL issue no trigger and go directly to COOLDOWN.
REQ-022 ISSUE (one cycle): exactly one trigger high; trigger outputs SHALL never be multi-hot; turn_count increments by 1 mod 256.
REQ-023 WAIT_ACK: is_turning=1 -> WAIT_DONE; ACK_TIMEOUT cycles without it -> set ack_error, go to SETTLE (retry).
REQ-024 WAIT_DONE: move_forward=0; is_turning=0 -> COOLDOWN.
REQ-025 COOLDOWN: move_forward=1; counter runs COOLDOWN_TIME cycles, then FORWARD; left/right openings ignored; front=1 aborts immediately to SETTLE.
REQ-026 Filtered values during SETTLE SHALL NOT abort the settle; DECIDE samples the values present in its cycle.
REQ-027 enable=0 in any state SHALL force IDLE next cycle, clear all counters except turn_count, and drive triggers and move_forward to 0 that cycle; ack_error is kept.
REQ-028 Triggers SHALL be registered outputs, high for exactly one cycle per ISSUE.

Reset
REQ-029 rst_n=0 at a rising edge SHALL set state IDLE, all triggers 0, move_forward 0, turn_count 0, ack_error 0, debounce and state counters 0, filtered detectors 1 (wall).
REQ-030 Reset mid-operation (any state, including ISSUE) SHALL take effect in the same edge with no trigger emitted afterward.
REQ-031 Reset SHALL take priority over enable.

Verification
REQ-032 Reset, enable=1, all detectors 1 except front=0 -> FORWARD, move_forward=1, no triggers for 1000 cycles.
REQ-033 In FORWARD, left goes 0 for 4 cycles then back to 1 -> no state change; left held 0 -> SETTLE after 5 cycles, 50 cycles later a single trigger_turn_left pulse, turn_count=1.
REQ-034 front=1, left=1, right=1 at DECIDE -> trigger_turn_back only; with is_turning raised 2 cycles later and held 900 cycles -> WAIT_DONE then COOLDOWN, move_forward=1.
REQ-035 Trigger issued, is_turning held 0 -> after 8 cycles ack_error=1, FSM back in SETTLE, second trigger after a further 50 cycles, turn_count=2.
REQ-036 During COOLDOWN, right opens -> ignored; front=1 debounced -> SETTLE before cooldown expires; enable dropped in WAIT_DONE -> IDLE next cycle, all outputs 0 except turn_count and ack_error.

Source files
------------

// File: rtl/auto_decision.sv
// auto_decision: debounced wall-detector junction FSM issuing one-shot turn requests
module auto_decision #(
    parameter int DEBOUNCE_CYCLES = 5,
    parameter int SETTLE_TIME = 50,
    parameter int ACK_TIMEOUT = 8,
    parameter int COOLDOWN_TIME = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       detector_front,
    input  logic       detector_left,
    input  logic       detector_right,
    input  logic       is_turning,
    output logic       trigger_turn_left,
    output logic       trigger_turn_right,
    output logic       trigger_turn_back,
    output logic       move_forward,
    output logic [7:0] turn_count,
    output logic       ack_error
);
    typedef enum logic [2:0] {IDLE, FORWARD, SETTLE, DECIDE, ISSUE, WAIT_ACK, WAIT_DONE, COOLDOWN} state_t;
    state_t state, state_nx;
    logic [2:0] raw, filt;
    logic [2:0][7:0] dcnt;
    logic [15:0] cnt;
    logic [2:0] trig, trig_nx;
    logic front, left, right;
    assign raw = {detector_front, detector_left, detector_right};
    assign {front, left, right} = filt;
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                filt[i] <= 1'b1;
                dcnt[i] <= '0;
            end else if (!enable || raw[i] == filt[i]) begin
                dcnt[i] <= '0;
            end else if (dcnt[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
                filt[i] <= raw[i];
                dcnt[i] <= '0;
            end else begin
                dcnt[i] <= dcnt[i] + 8'd1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            trig <= '0;
            turn_count <= '0;
            ack_error <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= (state_nx != state || !enable) ? '0 : cnt + {15'd0, cnt != '1};
            trig <= trig_nx;
            if (enable && state == ISSUE) turn_count <= turn_count + 8'd1;
            if (enable && state == WAIT_ACK && !is_turning && cnt >= 16'(ACK_TIMEOUT - 1)) ack_error <= 1'b1;
        end
    end
    always_comb begin
        state_nx = state;
        trig_nx = 3'b000;
        if (!enable) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:      state_nx = FORWARD;
                FORWARD:   state_nx = (front || !left || !right) ? SETTLE : FORWARD;
                SETTLE:    state_nx = (cnt >= 16'(SETTLE_TIME - 1) && !is_turning) ? DECIDE : SETTLE;
                DECIDE: begin
                    trig_nx = !left ? 3'b001 : !front ? 3'b000 : !right ? 3'b010 : 3'b100;
                    state_nx = (trig_nx == 3'b000) ? COOLDOWN : ISSUE;
                end
                ISSUE:     state_nx = WAIT_ACK;
                WAIT_ACK:  state_nx = is_turning ? WAIT_DONE : (cnt >= 16'(ACK_TIMEOUT - 1)) ? SETTLE : WAIT_ACK;
                WAIT_DONE: state_nx = is_turning ? WAIT_DONE : COOLDOWN;
                COOLDOWN:  state_nx = front ? SETTLE : (cnt >= 16'(COOLDOWN_TIME - 1)) ? FORWARD : COOLDOWN;
            endcase
        end
    end
    always_comb begin
        move_forward = enable && (state == FORWARD || state == COOLDOWN);
        {trigger_turn_back, trigger_turn_right, trigger_turn_left} = enable ? trig : 3'b000;
    end
endmodule

// File: tb/tb_auto_decision.sv
// tb_auto_decision: directed vector table plus reset/abort sequences for auto_decision
module tb_auto_decision;
    logic clk = 1'b0;
    logic rst_n, enable, det_f, det_l, det_r, turning;
    logic trg_l, trg_r, trg_b, mf, err;
    logic [7:0] count;
    int checks = 0, failures = 0, pl = 0, pr = 0, pb = 0;

    typedef struct {
        logic en, f, l, r, t;
        int n;
        logic mf;
        logic [2:0] trig;
        logic [7:0] count;
        logic err;
        int dl, dr, db;
    } vec_t;
    vec_t q[$];

    auto_decision dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .detector_front(det_f), .detector_left(det_l), .detector_right(det_r),
        .is_turning(turning),
        .trigger_turn_left(trg_l), .trigger_turn_right(trg_r), .trigger_turn_back(trg_b),
        .move_forward(mf), .turn_count(count), .ack_error(err)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #2;
        pl += trg_l ? 1 : 0;
        pr += trg_r ? 1 : 0;
        pb += trg_b ? 1 : 0;
        checks++;
        if ($countones({trg_b, trg_r, trg_l}) > 1) begin
            failures++;
            $display("FAIL onehot triggers got=%b", {trg_b, trg_r, trg_l});
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic en, f, l, r, t, input int n, input logic m,
                                input logic [2:0] tr, input logic [7:0] c, input logic e,
                                input int a, input int b, input int d);
        vec_t v;
        v = '{en, f, l, r, t, n, m, tr, c, e, a, b, d};
        q.push_back(v);
    endfunction

    initial begin
        int sl, sr, sb, sp;
        logic seen;
        //  en f  l  r  t  n    mf trig    cnt err  pulses l r b
        add(1, 0, 1, 1, 0, 1,   1, 3'b000, 0, 0,   0, 0, 0);
        add(1, 0, 1, 1, 0, 9,   0, 3'b000, 0, 0,   0, 0, 0);
        add(1, 0, 1, 1, 0, 50,  1, 3'b000, 0, 0,   0, 0, 0);
        add(1, 0, 1, 1, 0, 940, 1, 3'b000, 0, 0,   0, 0, 0);
        add(1, 0, 0, 1, 0, 4,   1, 3'b000, 0, 0,   0, 0, 0);
        add(1, 0, 1, 1, 0, 10,  1, 3'b000, 0, 0,   0, 0, 0);
        add(1, 0, 0, 1, 0, 5,   1, 3'b000, 0, 0,   0, 0, 0);
        add(1, 0, 0, 1, 0, 1,   0, 3'b000, 0, 0,   0, 0, 0);
        add(1, 0, 0, 1, 0, 50,  0, 3'b000, 0, 0,   0, 0, 0);
        add(1, 0, 0, 1, 0, 1,   0, 3'b001, 0, 0,   1, 0, 0);
        add(1, 0, 0, 1, 0, 1,   0, 3'b000, 1, 0,   0, 0, 0);
        add(1, 0, 0, 1, 0, 7,   0, 3'b000, 1, 0,   0, 0, 0);
        add(1, 0, 0, 1, 0, 1,   0, 3'b000, 1, 1,   0, 0, 0);
        add(1, 0, 0, 1, 0, 51,  0, 3'b001, 1, 1,   1, 0, 0);
        add(1, 0, 0, 1, 0, 1,   0, 3'b000, 2, 1,   0, 0, 0);
        add(1, 0, 1, 1, 1, 1,   0, 3'b000, 2, 1,   0, 0, 0);
        add(1, 0, 1, 1, 1, 20,  0, 3'b000, 2, 1,   0, 0, 0);
        add(1, 0, 1, 1, 0, 1,   1, 3'b000, 2, 1,   0, 0, 0);
        add(1, 0, 1, 0, 0, 20,  1, 3'b000, 2, 1,   0, 0, 0);
        add(1, 1, 1, 0, 0, 5,   1, 3'b000, 2, 1,   0, 0, 0);
        add(1, 1, 1, 0, 0, 1,   0, 3'b000, 2, 1,   0, 0, 0);
        add(1, 1, 1, 1, 0, 50,  0, 3'b000, 2, 1,   0, 0, 0);
        add(1, 1, 1, 1, 0, 1,   0, 3'b100, 2, 1,   0, 0, 1);
        add(1, 1, 1, 1, 0, 1,   0, 3'b000, 3, 1,   0, 0, 0);
        add(1, 1, 1, 1, 0, 1,   0, 3'b000, 3, 1,   0, 0, 0);
        add(1, 1, 1, 1, 1, 1,   0, 3'b000, 3, 1,   0, 0, 0);
        add(1, 1, 1, 1, 1, 900, 0, 3'b000, 3, 1,   0, 0, 0);
        add(1, 1, 1, 1, 0, 1,   1, 3'b000, 3, 1,   0, 0, 0);
        add(1, 1, 1, 1, 0, 1,   0, 3'b000, 3, 1,   0, 0, 0);
        add(1, 1, 0, 1, 0, 50,  0, 3'b000, 3, 1,   0, 0, 0);
        add(1, 1, 0, 1, 0, 1,   0, 3'b001, 3, 1,   1, 0, 0);
        add(1, 1, 0, 1, 1, 1,   0, 3'b000, 4, 1,   0, 0, 0);
        add(1, 1, 0, 1, 1, 1,   0, 3'b000, 4, 1,   0, 0, 0);
        add(0, 1, 0, 1, 1, 1,   0, 3'b000, 4, 1,   0, 0, 0);
        add(1, 0, 1, 1, 0, 1,   1, 3'b000, 4, 1,   0, 0, 0);

        rst_n = 1'b0; enable = 1'b1; det_f = 1'b0; det_l = 1'b1; det_r = 1'b1; turning = 1'b0;
        repeat (3) @(negedge clk);
        check("reset move_forward", mf, 0);
        check("reset triggers", {trg_b, trg_r, trg_l}, 0);
        check("reset turn_count", count, 0);
        check("reset ack_error", err, 0);
        rst_n = 1'b1;

        foreach (q[i]) begin
            {enable, det_f, det_l, det_r, turning} = {q[i].en, q[i].f, q[i].l, q[i].r, q[i].t};
            sl = pl; sr = pr; sb = pb;
            repeat (q[i].n) @(negedge clk);
            check($sformatf("v%0d move_forward", i), mf, q[i].mf);
            check($sformatf("v%0d triggers", i), {trg_b, trg_r, trg_l}, q[i].trig);
            check($sformatf("v%0d turn_count", i), count, q[i].count);
            check($sformatf("v%0d ack_error", i), err, q[i].err);
            check($sformatf("v%0d left_pulses", i), pl - sl, q[i].dl);
            check($sformatf("v%0d right_pulses", i), pr - sr, q[i].dr);
            check($sformatf("v%0d back_pulses", i), pb - sb, q[i].db);
        end

        det_l = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            seen = trg_l;
        end
        check("mid_issue trigger_seen", seen, 1);
        check("mid_issue turn_count", count, 4);
        rst_n = 1'b0;
        sp = pl + pr + pb;
        @(negedge clk);
        check("mid_reset move_forward", mf, 0);
        check("mid_reset triggers", {trg_b, trg_r, trg_l}, 0);
        check("mid_reset turn_count", count, 0);
        check("mid_reset ack_error", err, 0);
        repeat (20) @(negedge clk);
        check("held_reset pulses", pl + pr + pb - sp, 0);
        check("held_reset move_forward", mf, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset move_forward", mf, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
